rx_ipv4: RTL

//  IPv4 receive stage: consumes the Ethernet payload stream (EtherType 0x0800 already

---
 rtl/rx_ipv4.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rx_ipv4.sv
// IPv4 receive stage: parses and validates the IPv4 header, strips header, options and
// Ethernet padding, and forwards only the IP payload bytes downstream.
module rx_ipv4 #(
    parameter int             OCT   = 8,
    parameter logic [OCT-1:0] PROTO = 8'd17
) (
    input  logic           RX_CLK,
    input  logic           rst,
    input  logic [31:0]    ip_addr,
    input  logic           rx_data_v,
    input  logic [OCT-1:0] rx_data,
    output logic [31:0]    rx_src_ip,
    output logic [OCT-1:0] rx_protocol,
    output logic           rx_ip_data_v,
    output logic [OCT-1:0] rx_ip_data,
    output logic           rx_hdr_err
);

    typedef enum logic [1:0] {S_HEADER, S_PAYLOAD, S_DROP} state_t;

    state_t         r_state;
    logic [15:0]    r_cnt;
    logic [15:0]    r_sum;
    logic [OCT-1:0] r_hi;
    logic [3:0]     r_ver;
    logic [3:0]     r_ihl;
    logic [15:0]    r_tlen;
    logic [31:0]    r_dst;
    logic [15:0]    r_rem;
    logic [31:0]    r_src_ip;
    logic [OCT-1:0] r_protocol;
    logic           r_ip_data_v;
    logic [OCT-1:0] r_ip_data;
    logic           r_hdr_err;

    logic [16:0] w_add;
    logic [15:0] w_sum_next;
    logic [15:0] w_hlen;
    logic [15:0] w_plen;
    logic [31:0] w_dst;
    logic        w_last;
    logic        w_accept;

    always_comb begin
        // End-around carry: the 17-bit sum never overflows again after adding the carry back.
        w_add      = {1'b0, r_sum} + {1'b0, r_hi, rx_data};
        w_sum_next = w_add[15:0] + {15'd0, w_add[16]};
        w_hlen     = {10'd0, r_ihl, 2'b00};
        w_plen     = r_tlen - w_hlen;
        w_dst      = (r_cnt == 16'd19) ? {r_dst[23:0], rx_data} : r_dst;
        w_last     = (r_cnt >= 16'd19) &&
                     ((r_ihl < 4'd5) ? (r_cnt == 16'd19) : (r_cnt == w_hlen - 16'd1));
        w_accept   = (r_ver == 4'd4) && (r_ihl >= 4'd5) && (r_protocol == PROTO) &&
                     (w_dst == ip_addr) && (w_sum_next == 16'hFFFF) && (r_tlen >= w_hlen);
    end

    always_ff @(posedge RX_CLK) begin
        if (rst || !rx_data_v) begin
            r_state     <= S_HEADER;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_ip_data_v <= 1'b0;
            r_hdr_err   <= 1'b0;
            if (rst) begin
                r_src_ip   <= '0;
                r_protocol <= '0;
                r_ip_data  <= '0;
                r_hi       <= '0;
                r_ver      <= '0;
                r_ihl      <= '0;
                r_tlen     <= '0;
                r_dst      <= '0;
                r_rem      <= '0;
            end
        end else begin
            r_hdr_err <= 1'b0;
            case (r_state)
                S_HEADER: begin
                    r_ip_data_v <= 1'b0;
                    r_cnt       <= r_cnt + 16'd1;
                    if (!r_cnt[0]) r_hi  <= rx_data;
                    else           r_sum <= w_sum_next;
                    case (r_cnt)
                        16'd0:  {r_ver, r_ihl} <= rx_data;
                        16'd2:  r_tlen[15:8]   <= rx_data;
                        16'd3:  r_tlen[7:0]    <= rx_data;
                        16'd9:  r_protocol     <= rx_data;
                        16'd12, 16'd13, 16'd14, 16'd15: r_src_ip <= {r_src_ip[23:0], rx_data};
                        16'd16, 16'd17, 16'd18, 16'd19: r_dst    <= {r_dst[23:0], rx_data};
                        default: ;
                    endcase
                    if (w_last) begin
                        if (!w_accept) begin
                            r_state   <= S_DROP;
                            r_hdr_err <= 1'b1;
                        end else if (w_plen == 16'd0) begin
                            r_state <= S_DROP;
                        end else begin
                            r_state <= S_PAYLOAD;
                            r_rem   <= w_plen;
                        end
                    end
                end
                S_PAYLOAD: begin
                    r_ip_data   <= rx_data;
                    r_ip_data_v <= 1'b1;
                    r_rem       <= r_rem - 16'd1;
                    if (r_rem == 16'd1) r_state <= S_DROP;
                end
                default: begin
                    r_ip_data_v <= 1'b0;
                end
            endcase
        end
    end

    assign rx_src_ip    = r_src_ip;
    assign rx_protocol  = r_protocol;
    assign rx_ip_data_v = r_ip_data_v;
    assign rx_ip_data   = r_ip_data;
    assign rx_hdr_err   = r_hdr_err;

endmodule
